// File: rtl/snake_game_core.sv
// Snake game engine: owns snake segments, length, food and game state on a
// 32x24 cell grid; advances one move per tick and relocates food via an LFSR.
module snake_game_core #(
   parameter int unsigned GRID_W    = 32,
   parameter int unsigned GRID_H    = 24,
   parameter int unsigned INIT_LEN  = 3,
   parameter int unsigned MAX_LEN   = 63,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         clrn,
   input  logic         tick,
   input  logic [1:0]   dir_in,
   input  logic         dir_valid,
   input  logic         start,
   output logic [1:0]   game_state,
   output logic [5:0]   snake_length,
   output logic [319:0] snake_x_1dim,
   output logic [319:0] snake_y_1dim,
   output logic [4:0]   food_x,
   output logic [4:0]   food_y
);

   localparam int unsigned NSEG = 64;
   localparam int unsigned CW   = 5;
   localparam int unsigned LW   = 6;
   localparam int unsigned VW   = NSEG * CW;

   localparam logic [1:0] ST_RUN  = 2'b00;
   localparam logic [1:0] ST_DIE  = 2'b01;
   localparam logic [1:0] ST_INIT = 2'b10;

   localparam logic PH_MOVE = 1'b0;
   localparam logic PH_FOOD = 1'b1;

   localparam logic [1:0] D_UP    = 2'b00;
   localparam logic [1:0] D_DOWN  = 2'b01;
   localparam logic [1:0] D_RIGHT = 2'b10;

   localparam logic [VW-1:0] INIT_X = VW'({5'd14, 5'd15, 5'd16});
   localparam logic [VW-1:0] INIT_Y = VW'({5'd12, 5'd12, 5'd12});

   logic [1:0]    state_q, state_d;
   logic          phase_q, phase_d;
   logic [LW-1:0] len_q, len_d;
   logic [1:0]    cur_dir_q, cur_dir_d;
   logic [1:0]    pend_dir_q, pend_dir_d;
   logic [VW-1:0] seg_x_q, seg_x_d;
   logic [VW-1:0] seg_y_q, seg_y_d;
   logic [CW-1:0] food_x_q, food_x_d;
   logic [CW-1:0] food_y_q, food_y_d;
   logic [15:0]   lfsr_q, lfsr_d;

   logic [CW-1:0] head_x, head_y, next_x, next_y;
   logic          wall_hit, eat, body_hit, cand_bad;
   logic [LW:0]   body_lim;
   logic [CW-1:0] cand_x, cand_y;

   // Next head position, wall/eat detection, body collision and food candidate test
   always_comb begin
      head_x   = seg_x_q[CW-1:0];
      head_y   = seg_y_q[CW-1:0];
      next_x   = head_x;
      next_y   = head_y;
      wall_hit = 1'b0;
      case (pend_dir_q)
         D_UP: begin
            wall_hit = (head_y == 5'd0);
            next_y   = head_y - 5'd1;
         end
         D_DOWN: begin
            wall_hit = (head_y == 5'(GRID_H - 1));
            next_y   = head_y + 5'd1;
         end
         D_RIGHT: begin
            wall_hit = (head_x == 5'(GRID_W - 1));
            next_x   = head_x + 5'd1;
         end
         default: begin
            wall_hit = (head_x == 5'd0);
            next_x   = head_x - 5'd1;
         end
      endcase
      eat      = (next_x == food_x_q) && (next_y == food_y_q);
      // The tail cell is vacated on a non-eating move, so it is excluded then
      body_lim = eat ? {1'b0, len_q} : ({1'b0, len_q} - 7'd1);
      body_hit = 1'b0;
      cand_x   = lfsr_q[4:0];
      cand_y   = lfsr_q[9:5];
      cand_bad = (cand_y >= 5'(GRID_H));
      for (int i = 0; i < NSEG; i++) begin
         if ((7'(i) < body_lim) && (seg_x_q[CW*i +: CW] == next_x) &&
             (seg_y_q[CW*i +: CW] == next_y))
            body_hit = 1'b1;
         if ((7'(i) < {1'b0, len_q}) && (seg_x_q[CW*i +: CW] == cand_x) &&
             (seg_y_q[CW*i +: CW] == cand_y))
            cand_bad = 1'b1;
      end
   end

   // Game state machine and next-state for all game registers
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      len_d      = len_q;
      cur_dir_d  = cur_dir_q;
      pend_dir_d = pend_dir_q;
      seg_x_d    = seg_x_q;
      seg_y_d    = seg_y_q;
      food_x_d   = food_x_q;
      food_y_d   = food_y_q;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (state_q)
         ST_INIT: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            // A direct reversal would fold the head into the neck; drop it
            if (dir_valid && (dir_in != (cur_dir_q ^ 2'b01))) pend_dir_d = dir_in;
            if (phase_q == PH_MOVE) begin
               if (tick) begin
                  cur_dir_d = pend_dir_q;
                  if (wall_hit || body_hit) begin
                     state_d = ST_DIE;
                  end else begin
                     seg_x_d = {seg_x_q[VW-CW-1:0], next_x};
                     seg_y_d = {seg_y_q[VW-CW-1:0], next_y};
                     if (eat) begin
                        if (len_q != 6'(MAX_LEN)) len_d = len_q + 6'd1;
                        phase_d = PH_FOOD;
                     end
                  end
               end
            end else if (!cand_bad) begin
               food_x_d = cand_x;
               food_y_d = cand_y;
               phase_d  = PH_MOVE;
            end
         end
         ST_DIE: begin
            if (start) begin
               state_d    = ST_INIT;
               phase_d    = PH_MOVE;
               len_d      = 6'(INIT_LEN);
               cur_dir_d  = D_RIGHT;
               pend_dir_d = D_RIGHT;
               seg_x_d    = INIT_X;
               seg_y_d    = INIT_Y;
               food_x_d   = 5'd24;
               food_y_d   = 5'd12;
               lfsr_d     = LFSR_SEED;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Game registers with asynchronous reset to the initial layout
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q    <= ST_INIT;
         phase_q    <= PH_MOVE;
         len_q      <= 6'(INIT_LEN);
         cur_dir_q  <= D_RIGHT;
         pend_dir_q <= D_RIGHT;
         seg_x_q    <= INIT_X;
         seg_y_q    <= INIT_Y;
         food_x_q   <= 5'd24;
         food_y_q   <= 5'd12;
         lfsr_q     <= LFSR_SEED;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         len_q      <= len_d;
         cur_dir_q  <= cur_dir_d;
         pend_dir_q <= pend_dir_d;
         seg_x_q    <= seg_x_d;
         seg_y_q    <= seg_y_d;
         food_x_q   <= food_x_d;
         food_y_q   <= food_y_d;
         lfsr_q     <= lfsr_d;
      end
   end

   assign game_state   = state_q;
   assign snake_length = len_q;
   assign snake_x_1dim = seg_x_q;
   assign snake_y_1dim = seg_y_q;
   assign food_x       = food_x_q;
   assign food_y       = food_y_q;

endmodule
